alu_pipe: RTL

Parametrised, registered successor to the 8-bit ALU: a width-generic MIPS-funct ALU with valid/ready handshakes on input and output, status flags, an iterative multi-cycle multiplier and an illegal-opcode error flag. It sits between the operand/opcode source and the result consumer in the TP1 datapath. Single-cycle ops sustain one result per cycle under no backpressure.

---
 rtl/alu_pipe.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Registered, width-generic ALU driven by MIPS funct codes. Operands and
// results move through valid/ready handshakes. Single-cycle operations
// produce one result per cycle when the consumer never stalls. MULT runs an
// iterative shift-add multiplier that takes NB_DATA cycles. An opcode that is
// not in the table completes in one cycle with the error flag set.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous reset, active low
//   i_valid   : operand/opcode valid
//   o_ready   : block accepts an operation this cycle
//   i_opcode  : operation select (MIPS funct field)
//   i_ope1    : operand A
//   i_ope2    : operand B / shift amount
//   o_valid   : result valid
//   i_ready   : consumer accepts the result
//   o_result  : result
//   o_zero    : result is zero
//   o_carry   : ADD carry-out / SUB borrow
//   o_ovf     : ADD/SUB signed overflow, MULT high half nonzero
//   o_err     : opcode was not recognised
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_OP-1:0]   i_opcode,
    input  logic [NB_DATA-1:0] i_ope1,
    input  logic [NB_DATA-1:0] i_ope2,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_zero,
    output logic               o_carry,
    output logic               o_ovf,
    output logic               o_err
);

    localparam int SW  = $clog2(NB_DATA);
    localparam int MSB = NB_DATA - 1;

    localparam logic [NB_OP-1:0] OP_ADD  = NB_OP'(6'b100000);
    localparam logic [NB_OP-1:0] OP_SUB  = NB_OP'(6'b100010);
    localparam logic [NB_OP-1:0] OP_AND  = NB_OP'(6'b100100);
    localparam logic [NB_OP-1:0] OP_OR   = NB_OP'(6'b100101);
    localparam logic [NB_OP-1:0] OP_XOR  = NB_OP'(6'b100110);
    localparam logic [NB_OP-1:0] OP_NOR  = NB_OP'(6'b100111);
    localparam logic [NB_OP-1:0] OP_SRA  = NB_OP'(6'b000011);
    localparam logic [NB_OP-1:0] OP_SRL  = NB_OP'(6'b000010);
    localparam logic [NB_OP-1:0] OP_SLL  = NB_OP'(6'b000000);
    localparam logic [NB_OP-1:0] OP_SLT  = NB_OP'(6'b101010);
    localparam logic [NB_OP-1:0] OP_MULT = NB_OP'(6'b011000);

    localparam logic [SW-1:0] CNT_LAST = SW'(NB_DATA - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t               state_q;
    logic [NB_DATA-1:0]   result_q;
    logic                 zero_q;
    logic                 carry_q;
    logic                 ovf_q;
    logic                 err_q;

    logic [2*NB_DATA-1:0] mcand_q;
    logic [NB_DATA-1:0]   mplier_q;
    logic [2*NB_DATA-1:0] acc_q;
    logic [SW-1:0]        cnt_q;

    logic [NB_DATA-1:0]   res_d;
    logic                 zero_d;
    logic                 carry_d;
    logic                 ovf_d;
    logic                 err_d;
    logic [2*NB_DATA-1:0] acc_d;

    logic [NB_DATA:0]     sum;
    logic [NB_DATA:0]     diff;
    logic                 shiftBig;
    logic [SW-1:0]        shamt;
    logic                 accept;
    logic                 isMult;

    // In DONE the block can take a new operation only in the same cycle the
    // pending result leaves, so ready follows the consumer combinationally.
    assign o_ready  = (state_q == IDLE) || ((state_q == DONE) && i_ready);
    assign o_valid  = (state_q == DONE);
    assign o_result = result_q;
    assign o_zero   = zero_q;
    assign o_carry  = carry_q;
    assign o_ovf    = ovf_q;
    assign o_err    = err_q;

    assign accept = i_valid && o_ready;
    assign isMult = (i_opcode == OP_MULT);

    // Next accumulator value for one shift-add step of the multiplier.
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle ALU result and flags for the operands currently presented.
    always_comb begin
        sum      = {1'b0, i_ope1} + {1'b0, i_ope2};
        diff     = {1'b0, i_ope1} - {1'b0, i_ope2};
        // NB_DATA is a power of two, so any bit above the shift field means
        // the amount is at least NB_DATA.
        shiftBig = ((i_ope2 >> SW) != '0);
        shamt    = i_ope2[SW-1:0];
        res_d    = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        err_d    = 1'b0;
        case (i_opcode)
            OP_ADD: begin
                res_d   = sum[NB_DATA-1:0];
                carry_d = sum[NB_DATA];
                ovf_d   = (i_ope1[MSB] == i_ope2[MSB]) && (sum[MSB] != i_ope1[MSB]);
            end
            OP_SUB: begin
                res_d   = diff[NB_DATA-1:0];
                carry_d = diff[NB_DATA];
                ovf_d   = (i_ope1[MSB] != i_ope2[MSB]) && (diff[MSB] != i_ope1[MSB]);
            end
            OP_AND: res_d = i_ope1 & i_ope2;
            OP_OR:  res_d = i_ope1 | i_ope2;
            OP_XOR: res_d = i_ope1 ^ i_ope2;
            OP_NOR: res_d = ~(i_ope1 | i_ope2);
            OP_SRA: res_d = shiftBig ? {NB_DATA{i_ope1[MSB]}}
                                     : $unsigned($signed(i_ope1) >>> shamt);
            OP_SRL: res_d = shiftBig ? '0 : (i_ope1 >> shamt);
            OP_SLL: res_d = shiftBig ? '0 : (i_ope1 << shamt);
            OP_SLT: res_d = {{(NB_DATA-1){1'b0}}, ($signed(i_ope1) < $signed(i_ope2))};
            OP_MULT: res_d = '0;
            default: err_d = 1'b1;
        endcase
        zero_d = (res_d == '0);
    end

    // Control FSM together with the result/flag registers and the multiplier
    // datapath. Results are loaded only on accept or at the end of a MULT,
    // so they stay stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_q <= acc_d[NB_DATA-1:0];
                        zero_q   <= (acc_d[NB_DATA-1:0] == '0);
                        carry_q  <= 1'b0;
                        ovf_q    <= (acc_d[2*NB_DATA-1:NB_DATA] != '0);
                        err_q    <= 1'b0;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        if (isMult) begin
                            mcand_q  <= {{NB_DATA{1'b0}}, i_ope1};
                            mplier_q <= i_ope2;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            state_q  <= BUSY;
                        end else begin
                            result_q <= res_d;
                            zero_q   <= zero_d;
                            carry_q  <= carry_d;
                            ovf_q    <= ovf_d;
                            err_q    <= err_d;
                            state_q  <= DONE;
                        end
                    end else if ((state_q == DONE) && i_ready) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
